// File: rtl/pixel_stream_capture.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_capture
// Captures one VSYNC/HSYNC framed image into a buffer, checks line length and
// line count, and exposes a registered linear read port.
// Optional : CAPTURE_CHECKSUM_EN adds a 16-bit running sum of written pixels.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_stream_capture #(
  parameter int IMG_W  = 768,
  parameter int IMG_H  = 512,
  parameter int DATA_W = 8,
  localparam int ADDR_W = $clog2(IMG_W*IMG_H),
  localparam int ROW_W  = $clog2(IMG_H+1)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
`ifdef CAPTURE_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic              busy,
  output logic              capture_done,
  output logic [ROW_W-1:0]  row_count,
  output logic              err_len,
  output logic              err_frame
);

  localparam int COL_W = $clog2(IMG_W+1);
  localparam int DEPTH = IMG_W*IMG_H;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LINE = 2'd1,
    S_LINE      = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               vs_dly_q, hs_dly_q;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               err_len_q, err_len_d;
  logic               err_frame_q, err_frame_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               vs_rise, hs_fall;
  logic [DATA_W-1:0]  mem [DEPTH];

  assign vs_rise = VSYNC & ~vs_dly_q;
  assign hs_fall = ~HSYNC & hs_dly_q;
  assign wr_addr = ADDR_W'(row_q) * ADDR_W'(IMG_W) + ADDR_W'(col_q);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    err_len_d   = err_len_q;
    err_frame_d = err_frame_q;
    wr_en       = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (vs_rise) begin
          state_d     = S_WAIT_LINE;
          row_d       = '0;
          col_d       = '0;
          err_len_d   = 1'b0;
          err_frame_d = 1'b0;
        end
      end
      S_WAIT_LINE: begin
        if (vs_rise) begin
          err_frame_d = 1'b1;
          row_d       = '0;
          col_d       = '0;
        end else if (HSYNC) begin
          wr_en   = 1'b1;
          col_d   = COL_W'(1);
          state_d = S_LINE;
        end
      end
      S_LINE: begin
        // A frame restart wins over any pixel presented in the same cycle.
        if (vs_rise) begin
          err_frame_d = 1'b1;
          row_d       = '0;
          col_d       = '0;
          state_d     = S_WAIT_LINE;
        end else if (HSYNC) begin
          if (col_q == COL_W'(IMG_W)) begin
            err_len_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            col_d = col_q + COL_W'(1);
          end
        end else if (hs_fall) begin
          if (col_q != COL_W'(IMG_W)) err_len_d = 1'b1;
          row_d   = row_q + ROW_W'(1);
          col_d   = '0;
          state_d = (row_q + ROW_W'(1) == ROW_W'(IMG_H)) ? S_DONE : S_WAIT_LINE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH)) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      vs_dly_q    <= 1'b0;
      hs_dly_q    <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      err_len_q   <= 1'b0;
      err_frame_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      vs_dly_q    <= VSYNC;
      hs_dly_q    <= HSYNC;
      row_q       <= row_d;
      col_q       <= col_d;
      err_len_q   <= err_len_d;
      err_frame_q <= err_frame_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Buffer contents survive reset; only the write strobe is suppressed.
  always_ff @(posedge HCLK) begin
    if (wr_en && !HRESET) mem[wr_addr] <= data;
  end

`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (vs_rise)    checksum_d = '0;
    else if (wr_en) checksum_d = checksum_q + 16'(data);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  assign rd_data      = rd_data_q;
  assign busy         = (state_q == S_WAIT_LINE) || (state_q == S_LINE);
  assign capture_done = (state_q == S_DONE);
  assign row_count    = row_q;
  assign err_len      = err_len_q;
  assign err_frame    = err_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_capture
// Directed self-checking bench for pixel_stream_capture with a 4x3 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_capture;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int DATA_W = 8;
  localparam int ADDR_W = $clog2(IMG_W*IMG_H);
  localparam int ROW_W  = $clog2(IMG_H+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              vsync;
  logic              hsync;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              capture_done;
  logic [ROW_W-1:0]  row_count;
  logic              err_len;
  logic              err_frame;
`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_stream_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W)) dut (
    .HCLK         (clk),
    .HRESET       (rst),
    .VSYNC        (vsync),
    .HSYNC        (hsync),
    .data         (data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
`ifdef CAPTURE_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .busy         (busy),
    .capture_done (capture_done),
    .row_count    (row_count),
    .err_len      (err_len),
    .err_frame    (err_frame)
  );

  task automatic cyc(input logic vs, input logic hs, input logic [DATA_W-1:0] d);
    vsync = vs;
    hsync = hs;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic send_line(input logic [DATA_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, DATA_W'(base + i));
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic read_at(input int a);
    rd_addr = ADDR_W'(a);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_addr = '0;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (capture_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", capture_done); end
    checks++; if (row_count !== '0) begin errors++; $display("FAIL reset_row got %0d exp 0", row_count); end
    checks++; if ({err_len, err_frame} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {err_len, err_frame}); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_basic_frame();
    frame_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b exp 1", busy); end
    send_line(8'h01, 4);
    send_line(8'h05, 4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, DATA_W'(8'h09 + i));
    checks++; if (capture_done !== 1'b0) begin errors++; $display("FAIL basic_done_early got %0b exp 0", capture_done); end
    cyc(1'b0, 1'b0, '0);
    checks++; if (capture_done !== 1'b1) begin errors++; $display("FAIL basic_done got %0b exp 1", capture_done); end
    checks++; if (row_count !== ROW_W'(3)) begin errors++; $display("FAIL basic_row got %0d exp 3", row_count); end
    checks++; if ({busy, err_len, err_frame} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b exp 000", {busy, err_len, err_frame}); end
`ifdef CAPTURE_CHECKSUM_EN
    checks++; if (checksum !== 16'h004E) begin errors++; $display("FAIL basic_checksum got %h exp 004e", checksum); end
`endif
    cyc(1'b0, 1'b0, '0);
    for (int a = 0; a < 12; a++) begin
      read_at(a);
      checks++; if (rd_data !== DATA_W'(a + 1)) begin errors++; $display("FAIL basic_read[%0d] got %h exp %h", a, rd_data, DATA_W'(a + 1)); end
    end
  endtask

  task automatic test_long_line();
    logic [DATA_W-1:0] exp_mem [12];
    exp_mem = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    frame_start();
    send_line(8'hB0, 4);
    send_line(8'hA0, 6);
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL long_err_len got %0b exp 1", err_len); end
    checks++; if (row_count !== ROW_W'(2)) begin errors++; $display("FAIL long_row got %0d exp 2", row_count); end
    send_line(8'hC0, 4);
    checks++; if (capture_done !== 1'b1) begin errors++; $display("FAIL long_done got %0b exp 1", capture_done); end
`ifdef CAPTURE_CHECKSUM_EN
    checks++; if (checksum !== 16'h0852) begin errors++; $display("FAIL long_checksum got %h exp 0852", checksum); end
`endif
    for (int a = 0; a < 12; a++) begin
      read_at(a);
      checks++; if (rd_data !== exp_mem[a]) begin errors++; $display("FAIL long_read[%0d] got %h exp %h", a, rd_data, exp_mem[a]); end
    end
  endtask

  task automatic test_short_line();
    logic [DATA_W-1:0] exp_mem [5];
    exp_mem = '{8'h20, 8'h21, 8'hB2, 8'hB3, 8'h30};
    frame_start();
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL short_err_cleared got %0b exp 0", err_len); end
    send_line(8'h20, 2);
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL short_err_len got %0b exp 1", err_len); end
    checks++; if (row_count !== ROW_W'(1)) begin errors++; $display("FAIL short_row got %0d exp 1", row_count); end
    send_line(8'h30, 4);
    send_line(8'h40, 4);
    checks++; if (capture_done !== 1'b1) begin errors++; $display("FAIL short_done got %0b exp 1", capture_done); end
    for (int a = 0; a < 5; a++) begin
      read_at(a);
      checks++; if (rd_data !== exp_mem[a]) begin errors++; $display("FAIL short_read[%0d] got %h exp %h", a, rd_data, exp_mem[a]); end
    end
  endtask

  task automatic test_frame_restart();
    frame_start();
    send_line(8'h50, 4);
    cyc(1'b0, 1'b1, 8'h60);
    cyc(1'b0, 1'b1, 8'h61);
    cyc(1'b1, 1'b1, 8'h62);
    checks++; if (err_frame !== 1'b1) begin errors++; $display("FAIL restart_err_frame got %0b exp 1", err_frame); end
    checks++; if (row_count !== '0) begin errors++; $display("FAIL restart_row got %0d exp 0", row_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %0b exp 1", busy); end
    cyc(1'b0, 1'b0, '0);
    send_line(8'h70, 4);
    send_line(8'h74, 4);
    send_line(8'h78, 4);
    checks++; if (capture_done !== 1'b1) begin errors++; $display("FAIL restart_done got %0b exp 1", capture_done); end
    checks++; if ({err_frame, err_len} !== 2'b10) begin errors++; $display("FAIL restart_flags got %b exp 10", {err_frame, err_len}); end
`ifdef CAPTURE_CHECKSUM_EN
    checks++; if (checksum !== 16'h0582) begin errors++; $display("FAIL restart_checksum got %h exp 0582", checksum); end
`endif
    for (int a = 0; a < 12; a++) begin
      read_at(a);
      checks++; if (rd_data !== DATA_W'(8'h70 + a)) begin errors++; $display("FAIL restart_read[%0d] got %h exp %h", a, rd_data, DATA_W'(8'h70 + a)); end
    end
  endtask

  task automatic test_mid_reset();
    frame_start();
    cyc(1'b0, 1'b1, 8'h90);
    cyc(1'b0, 1'b1, 8'h91);
    cyc(1'b1, 1'b1, 8'h92);
    cyc(1'b0, 1'b1, 8'h93);
    cyc(1'b0, 1'b1, 8'h94);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 8'hEE);
    rst = 1'b0;
    checks++; if ({busy, capture_done} !== 2'b00) begin errors++; $display("FAIL mreset_state got %b exp 00", {busy, capture_done}); end
    checks++; if (row_count !== '0) begin errors++; $display("FAIL mreset_row got %0d exp 0", row_count); end
    checks++; if ({err_len, err_frame} !== 2'b00) begin errors++; $display("FAIL mreset_err got %b exp 00", {err_len, err_frame}); end
    send_line(8'hD0, 4);
    checks++; if ({busy, row_count} !== {1'b0, ROW_W'(0)}) begin errors++; $display("FAIL mreset_ignore got busy=%0b row=%0d exp 0 0", busy, row_count); end
    read_at(0);
    checks++; if (rd_data !== 8'h93) begin errors++; $display("FAIL mreset_read0 got %h exp 93", rd_data); end
    read_at(1);
    checks++; if (rd_data !== 8'h94) begin errors++; $display("FAIL mreset_read1 got %h exp 94", rd_data); end
    read_at(2);
    checks++; if (rd_data !== 8'h72) begin errors++; $display("FAIL mreset_read2 got %h exp 72", rd_data); end
    read_at(3);
    checks++; if (rd_data !== 8'h73) begin errors++; $display("FAIL mreset_read3 got %h exp 73", rd_data); end
  endtask

  task automatic test_back_to_back();
    frame_start();
    send_line(8'h01, 4);
    send_line(8'h05, 4);
    send_line(8'h09, 4);
    checks++; if (capture_done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %0b exp 1", capture_done); end
    rd_addr = '0;
    cyc(1'b1, 1'b0, '0);
    checks++; if ({capture_done, busy} !== 2'b01) begin errors++; $display("FAIL b2b_restart got %b exp 01", {capture_done, busy}); end
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 8'hF0);
    checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL b2b_rd_old got %h exp 01", rd_data); end
    cyc(1'b0, 1'b1, 8'hF1);
    checks++; if (rd_data !== 8'hF0) begin errors++; $display("FAIL b2b_rd_new got %h exp f0", rd_data); end
    cyc(1'b0, 1'b1, 8'hF2);
    cyc(1'b0, 1'b1, 8'hF3);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    send_line(8'hF4, 4);
    send_line(8'hF8, 4);
    checks++; if (capture_done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %0b exp 1", capture_done); end
    read_at(11);
    checks++; if (rd_data !== 8'hFB) begin errors++; $display("FAIL b2b_read11 got %h exp fb", rd_data); end
    read_at(12);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL b2b_read12 got %h exp 00", rd_data); end
    read_at(5);
    checks++; if (rd_data !== 8'hF5) begin errors++; $display("FAIL b2b_read5 got %h exp f5", rd_data); end
    read_at(15);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL b2b_read15 got %h exp 00", rd_data); end
  endtask

  initial begin
    vsync = 1'b0; hsync = 1'b0; data = '0; rd_addr = '0; rst = 1'b1;
    test_reset();
    test_basic_frame();
    test_long_line();
    test_short_line();
    test_frame_restart();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
